mmio_slot_arbiter: RTL and testbench

- Round-robin arbiter and transaction sequencer that shares one MMIO slot (the GPIO slot interface) between NUM_REQ requesters, e.g. the CPU load/store unit and the debug master.
- Owns the slot handshake end to end: chip_select/read/write issue, completion detection, transaction_completed pulse and response routing.
- Bounds every access with a timeout.

---
 rtl/mmio_slot_arbiter_if.sv | 47 ++++
 rtl/mmio_slot_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mmio_slot_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mmio_slot_arbiter_if.sv
`default_nettype none
// =============================================================================
// mmio_slot_arbiter_if -- requester + MMIO slot signals (arbiter's view) | rev 1.0
// =============================================================================
interface mmio_slot_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ-1:0]    req_write_i;
    logic [NUM_REQ*8-1:0]  req_addr_i;
    logic [NUM_REQ*32-1:0] req_wdata_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [NUM_REQ-1:0]    rsp_valid_o;
    logic [31:0]           rsp_rdata_o;
    logic                  rsp_slave_err_o;
    logic                  rsp_decode_err_o;
    logic                  rsp_timeout_o;
    logic                  chip_select_o;
    logic                  read_o;
    logic                  write_o;
    logic [7:0]            addr_o;
    logic [31:0]           wr_data_o;
    logic                  transaction_completed_o;
    logic [31:0]           rd_data_i;
    logic                  wr_done_i;
    logic                  rd_done_i;
    logic                  slave_error_i;
    logic                  decode_error_i;

    // master: requesters plus slot device; slave: the arbiter itself
    modport master (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
        output rd_data_i, wr_done_i, rd_done_i, slave_error_i, decode_error_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_slave_err_o,
        input  rsp_decode_err_o, rsp_timeout_o, chip_select_o, read_o, write_o,
        input  addr_o, wr_data_o, transaction_completed_o
    );

    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
        input  rd_data_i, wr_done_i, rd_done_i, slave_error_i, decode_error_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_slave_err_o,
        output rsp_decode_err_o, rsp_timeout_o, chip_select_o, read_o, write_o,
        output addr_o, wr_data_o, transaction_completed_o
    );
endinterface
`default_nettype wire

// File: rtl/mmio_slot_arbiter.sv
`default_nettype none
// =============================================================================
// mmio_slot_arbiter -- round-robin sharing of one MMIO slot with timeout | rev 1.0
// =============================================================================
module mmio_slot_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 16
) (
    input wire                  clk,
    input wire                  arst_n,
    mmio_slot_arbiter_if.slave  bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_BUSY     = 2'd1,
        S_COMPLETE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       last_q, last_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic                cs_q, cs_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [7:0]          addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                serr_q, serr_d;
    logic                derr_q, derr_d;
    logic                tmo_q, tmo_d;
    logic                tc_q, tc_d;

    logic                w_found;
    logic [IW-1:0]       w_gnt;
    logic [IW-1:0]       w_cand;
    logic                w_accept;
    logic                w_event;
    logic                w_expired;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IW'((int'(last_q) + k) % NUM_REQ);
            if (!w_found && bus.req_valid_i[w_cand]) begin
                w_found = 1'b1;
                w_gnt   = w_cand;
            end
        end
    end

    assign w_accept  = (state_q == S_IDLE) && w_found && arst_n;
    assign w_event   = bus.wr_done_i | bus.rd_done_i | bus.slave_error_i | bus.decode_error_i;
    assign w_expired = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        cs_d        = cs_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rsp_valid_d = '0;
        rdata_d     = '0;
        serr_d      = 1'b0;
        derr_d      = 1'b0;
        tmo_d       = 1'b0;
        tc_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d = S_BUSY;
                    last_d  = w_gnt;
                    owner_d = w_gnt;
                    cs_d    = 1'b1;
                    wr_d    = bus.req_write_i[w_gnt];
                    rd_d    = ~bus.req_write_i[w_gnt];
                    addr_d  = bus.req_addr_i[int'(w_gnt)*8 +: 8];
                    wdata_d = bus.req_write_i[w_gnt] ? bus.req_wdata_i[int'(w_gnt)*32 +: 32] : 32'h0;
                    cnt_d   = '0;
                end
            end
            S_BUSY: begin
                if (w_event || w_expired) begin
                    state_d     = S_COMPLETE;
                    cs_d        = 1'b0;
                    rd_d        = 1'b0;
                    wr_d        = 1'b0;
                    addr_d      = '0;
                    wdata_d     = '0;
                    rsp_valid_d = ONE_HOT0 << owner_q;
                    tc_d        = 1'b1;
                    // A real completion beats a coincident timeout
                    if (w_event) begin
                        rdata_d = (bus.rd_done_i && !bus.slave_error_i && !bus.decode_error_i)
                                  ? bus.rd_data_i : 32'h0;
                        serr_d  = bus.slave_error_i;
                        derr_d  = bus.decode_error_i;
                    end else begin
                        tmo_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_COMPLETE: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= S_IDLE;
            last_q      <= IW'(NUM_REQ - 1);
            owner_q     <= '0;
            cs_q        <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rdata_q     <= '0;
            serr_q      <= 1'b0;
            derr_q      <= 1'b0;
            tmo_q       <= 1'b0;
            tc_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            cs_q        <= cs_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            serr_q      <= serr_d;
            derr_q      <= derr_d;
            tmo_q       <= tmo_d;
            tc_q        <= tc_d;
        end
    end

    assign bus.req_ready_o             = w_accept ? (ONE_HOT0 << w_gnt) : '0;
    assign bus.rsp_valid_o             = rsp_valid_q;
    assign bus.rsp_rdata_o             = rdata_q;
    assign bus.rsp_slave_err_o         = serr_q;
    assign bus.rsp_decode_err_o        = derr_q;
    assign bus.rsp_timeout_o           = tmo_q;
    assign bus.chip_select_o           = cs_q;
    assign bus.read_o                  = rd_q;
    assign bus.write_o                 = wr_q;
    assign bus.addr_o                  = addr_q;
    assign bus.wr_data_o               = wdata_q;
    assign bus.transaction_completed_o = tc_q;
endmodule
`default_nettype wire

// File: tb/tb_mmio_slot_arbiter.sv
`default_nettype none
// tb_mmio_slot_arbiter -- random requesters and slot responses checked every cycle
// against a transaction-timeline model (grant cycle, busy length, response values).
module tb_mmio_slot_arbiter;
    localparam int NUM_REQ = 2;
    localparam int TIMEOUT = 16;
    localparam int NCYC    = 3000;

    logic clk    = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    mmio_slot_arbiter_if #(.NUM_REQ(NUM_REQ)) bus_if ();

    mmio_slot_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus_if)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    endtask

    // Requester-side state
    bit          pend [NUM_REQ];
    bit          pw   [NUM_REQ];
    logic [7:0]  pa   [NUM_REQ];
    logic [31:0] pd   [NUM_REQ];
    int          last;

    // Current slot transaction: granted at g_cyc, busy for blen cycles, done at g_cyc+blen+1
    bit          busy;
    int          g_cyc, owner, lat, blen, kind, rsel, rst_left;
    bit          t_w, cap, with_done;
    logic [7:0]  t_a;
    logic [31:0] t_d;
    bit          s_wd, s_rdn, s_se, s_de;
    logic [31:0] s_rdata, e_rdata;
    bit          e_se, e_de, e_tmo;

    initial begin
        logic [NUM_REQ-1:0]  exp_ready, ev;
        logic [42:0]         exp_slot;
        logic [NUM_REQ+35:0] exp_rsp;
        int                  grant;
        bit                  in_busy, done_now;

        bus_if.req_valid_i    = '0;
        bus_if.req_write_i    = '0;
        bus_if.req_addr_i     = '0;
        bus_if.req_wdata_i    = '0;
        bus_if.rd_data_i      = '0;
        bus_if.wr_done_i      = 1'b0;
        bus_if.rd_done_i      = 1'b0;
        bus_if.slave_error_i  = 1'b0;
        bus_if.decode_error_i = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
        last     = NUM_REQ - 1;
        busy     = 1'b0;
        g_cyc    = 0;
        owner    = 0;
        blen     = 0;
        lat      = 0;
        rst_left = 3;

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            if (rst_left > 0) begin
                arst_n = 1'b0;
                rst_left--;
            end else begin
                arst_n = 1'b1;
                if (busy && c == g_cyc + 2 && $urandom_range(0, 39) == 0) begin
                    arst_n   = 1'b0;
                    rst_left = 1;
                end
            end

            if (!arst_n) begin
                busy = 1'b0;
                last = NUM_REQ - 1;
                for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
            end else begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (pend[i] && $urandom_range(0, 31) == 0) pend[i] = 1'b0;
                    else if (!pend[i] && $urandom_range(0, 3) == 0) begin
                        pend[i] = 1'b1;
                        pw[i]   = 1'($urandom);
                        pa[i]   = 8'($urandom);
                        pd[i]   = $urandom;
                    end
                end
            end

            for (int i = 0; i < NUM_REQ; i++) begin
                bus_if.req_valid_i[i]          = pend[i];
                bus_if.req_write_i[i]          = pend[i] ? pw[i] : 1'($urandom);
                bus_if.req_addr_i[8*i +: 8]    = pend[i] ? pa[i] : 8'($urandom);
                bus_if.req_wdata_i[32*i +: 32] = pend[i] ? pd[i] : $urandom;
            end

            // Slot device: one response at g_cyc+lat, noise only outside the busy window
            in_busy = busy && c > g_cyc && c <= g_cyc + blen;
            bus_if.rd_data_i      = $urandom;
            bus_if.wr_done_i      = 1'b0;
            bus_if.rd_done_i      = 1'b0;
            bus_if.slave_error_i  = 1'b0;
            bus_if.decode_error_i = 1'b0;
            if (busy && lat != 0 && c == g_cyc + lat) begin
                bus_if.rd_data_i      = s_rdata;
                bus_if.wr_done_i      = s_wd;
                bus_if.rd_done_i      = s_rdn;
                bus_if.slave_error_i  = s_se;
                bus_if.decode_error_i = s_de;
            end else if (!in_busy && $urandom_range(0, 3) == 0) begin
                {bus_if.wr_done_i, bus_if.rd_done_i, bus_if.slave_error_i, bus_if.decode_error_i} = 4'($urandom);
            end

            grant = -1;
            if (arst_n && !busy)
                for (int k = 1; k <= NUM_REQ; k++)
                    if (grant < 0 && pend[(last + k) % NUM_REQ]) grant = (last + k) % NUM_REQ;

            exp_ready = '0;
            exp_slot  = '0;
            exp_rsp   = '0;
            done_now  = 1'b0;
            if (arst_n) begin
                if (grant >= 0) exp_ready[grant] = 1'b1;
                if (busy && c == g_cyc + blen + 1) begin
                    ev        = '0;
                    ev[owner] = 1'b1;
                    exp_rsp   = {ev, e_rdata, e_se, e_de, e_tmo, 1'b1};
                    done_now  = 1'b1;
                end else if (in_busy) begin
                    exp_slot = {1'b1, !t_w, t_w, t_a, (t_w ? t_d : 32'h0)};
                end
            end

            @(negedge clk);
            check_eq("req_ready", 64'(bus_if.req_ready_o), 64'(exp_ready));
            check_eq("slot", 64'({bus_if.chip_select_o, bus_if.read_o, bus_if.write_o,
                                  bus_if.addr_o, bus_if.wr_data_o}), 64'(exp_slot));
            check_eq("rsp", 64'({bus_if.rsp_valid_o, bus_if.rsp_rdata_o, bus_if.rsp_slave_err_o,
                                 bus_if.rsp_decode_err_o, bus_if.rsp_timeout_o,
                                 bus_if.transaction_completed_o}), 64'(exp_rsp));

            if (done_now) busy = 1'b0;
            if (grant >= 0) begin
                pend[grant] = 1'b0;
                last  = grant;
                busy  = 1'b1;
                g_cyc = c;
                owner = grant;
                t_w   = pw[grant];
                t_a   = pa[grant];
                t_d   = pd[grant];
                // Response time: mostly the 3-cycle GPIO slot, plus tie, late and silent cases
                rsel = $urandom_range(0, 9);
                if (rsel < 5)       lat = 3;
                else if (rsel < 7)  lat = $urandom_range(1, TIMEOUT);
                else if (rsel == 7) lat = TIMEOUT;
                else if (rsel == 8) lat = TIMEOUT + 1;
                else                lat = 0;
                kind      = $urandom_range(0, 4);
                with_done = 1'($urandom);
                s_rdata   = $urandom;
                s_se      = (kind == 3);
                s_de      = (kind == 4);
                s_wd      = t_w && (kind < 3 || (kind == 3 && with_done));
                s_rdn     = !t_w && (kind < 3 || with_done);
                cap       = (lat != 0) && (lat <= TIMEOUT);
                blen      = cap ? lat : TIMEOUT;
                e_se      = cap && s_se;
                e_de      = cap && s_de;
                e_tmo     = !cap;
                e_rdata   = (cap && s_rdn && !s_se && !s_de) ? s_rdata : 32'h0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
